// File: rtl/hpm_counter_bank_pkg.sv
// Shared types and constants for the hardware performance counter bank.
// The CSR write-op encoding matches the CSR unit: 1 = WRITE, 2 = SET, 3 = CLEAR.
package HPM_CounterTypes;

  localparam logic [11:0] CSR_MCOUNTINHIBIT     = 12'h320;
  localparam logic [11:0] CSR_MHPMEVENT_BASE    = 12'h323;
  localparam logic [11:0] CSR_MHPMCOUNTER_BASE  = 12'hB03;
  localparam logic [11:0] CSR_MHPMCOUNTERH_BASE = 12'hB83;

  localparam int HPM_FIRST_COUNTER = 3;
  localparam int HPM_OF_BIT        = 31;
  localparam int HPM_OFIE_BIT      = 30;

  typedef logic [7:0] HPM_EventSelPath;

  typedef enum logic [7:0] {
    HPM_EV_NONE              = 8'd0,
    HPM_EV_LOAD_MISS         = 8'd1,
    HPM_EV_STORE_MISS        = 8'd2,
    HPM_EV_ICACHE_MISS       = 8'd3,
    HPM_EV_BRANCH_MISPREDICT = 8'd4,
    HPM_EV_COMMITTED_OPS     = 8'd5,
    HPM_EV_LANE_6            = 8'd6,
    HPM_EV_LANE_7            = 8'd7,
    HPM_EV_LANE_8            = 8'd8
  } HPM_EventCode;

  typedef enum logic [1:0] {
    CSR_OP_NONE  = 2'd0,
    CSR_OP_WRITE = 2'd1,
    CSR_OP_SET   = 2'd2,
    CSR_OP_CLEAR = 2'd3
  } csr_op_e;

  function automatic logic [31:0] csr_apply_op(input logic [1:0]  op,
                                               input logic [31:0] rd,
                                               input logic [31:0] opnd);
    logic [31:0] res;
    case (op)
      CSR_OP_WRITE: res = opnd;
      CSR_OP_SET:   res = rd | opnd;
      CSR_OP_CLEAR: res = rd & ~opnd;
      default:      res = rd;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/hpm_counter_bank_slice.sv
// One performance counter: event selector, registered lane increment,
// the counter itself and its sticky overflow / interrupt-enable flags.
module hpm_counter_slice
  import HPM_CounterTypes::*;
#(
  parameter int COUNTER_WIDTH   = 64,
  parameter int NUM_EVENTS      = 8,
  parameter int EVENT_INC_WIDTH = 3
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  evt_we,
  input  logic                                  cnt_lo_we,
  input  logic                                  cnt_hi_we,
  input  logic [31:0]                           wdata,
  input  logic                                  inhibit,
  input  logic [NUM_EVENTS*EVENT_INC_WIDTH-1:0] event_inc,
  output logic [31:0]                           evt_rdata,
  output logic [31:0]                           cnt_lo_rdata,
  output logic [31:0]                           cnt_hi_rdata,
  output logic                                  irq_src
);

  localparam bit HAS_HI = COUNTER_WIDTH > 32;

  HPM_EventSelPath              sel_q, sel_d;
  logic                         of_q, of_d;
  logic                         ofie_q, ofie_d;
  logic [EVENT_INC_WIDTH-1:0]   inc_p1_q, inc_p1_d;
  logic [COUNTER_WIDTH-1:0]     cnt_p2_q, cnt_p2_d;
  logic [63:0]                  cnt_ext;
  logic [63:0]                  cnt_wr;
  logic [64:0]                  sum;
  logic                         carry;
  logic                         hi_we_eff;

  assign cnt_ext = 64'(cnt_p2_q);

  // Stage 1: capture the lane chosen by the selector as it stands this cycle
  always_comb begin
    inc_p1_d = '0;
    for (int k = 0; k < NUM_EVENTS; k++) begin
      if (sel_q == HPM_EventSelPath'(k + 1))
        inc_p1_d = event_inc[k*EVENT_INC_WIDTH +: EVENT_INC_WIDTH];
    end
  end

  // Stage 2: accumulate, unless software writes the counter on the same edge
  always_comb begin
    hi_we_eff = cnt_hi_we & HAS_HI;
    cnt_wr    = cnt_ext;
    if (cnt_lo_we) cnt_wr[31:0]  = wdata;
    if (hi_we_eff) cnt_wr[63:32] = wdata;

    sum   = 65'(cnt_p2_q) + 65'(inc_p1_q);
    carry = (sum >> COUNTER_WIDTH) != 65'd0;

    cnt_p2_d = cnt_p2_q;
    of_d     = of_q;
    sel_d    = sel_q;
    ofie_d   = ofie_q;

    if (cnt_lo_we | hi_we_eff) begin
      cnt_p2_d = cnt_wr[COUNTER_WIDTH-1:0];
    end else if (!inhibit) begin
      cnt_p2_d = sum[COUNTER_WIDTH-1:0];
      if (carry) of_d = 1'b1;
    end

    // A software write of OF overrides a hardware overflow on the same edge
    if (evt_we) begin
      sel_d  = wdata[7:0];
      of_d   = wdata[HPM_OF_BIT];
      ofie_d = wdata[HPM_OFIE_BIT];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q    <= '0;
      of_q     <= 1'b0;
      ofie_q   <= 1'b0;
      inc_p1_q <= '0;
      cnt_p2_q <= '0;
    end else begin
      sel_q    <= sel_d;
      of_q     <= of_d;
      ofie_q   <= ofie_d;
      inc_p1_q <= inc_p1_d;
      cnt_p2_q <= cnt_p2_d;
    end
  end

  assign evt_rdata    = {of_q, ofie_q, 22'd0, sel_q};
  assign cnt_lo_rdata = cnt_ext[31:0];
  assign cnt_hi_rdata = cnt_ext[63:32];
  assign irq_src      = of_q & ofie_q;

endmodule

// File: rtl/hpm_counter_bank.sv
// Machine HPM counter bank: CSR decode and read mux, mcountinhibit,
// one counter slice per mhpmcounter, and the registered overflow interrupt.
module hpm_counter_bank
  import HPM_CounterTypes::*;
#(
  parameter int NUM_COUNTERS    = 4,
  parameter int COUNTER_WIDTH   = 64,
  parameter int NUM_EVENTS      = 8,
  parameter int EVENT_INC_WIDTH = 3
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [11:0]                           csrNumber,
  input  logic                                  csrWE,
  input  logic [1:0]                            csrCode,
  input  logic [31:0]                           csrWriteIn,
  output logic                                  csrHit,
  output logic [31:0]                           csrReadOut,
  input  logic [NUM_EVENTS*EVENT_INC_WIDTH-1:0] eventInc,
  output logic                                  overflowIrq
);

  localparam logic [31:0] INHIBIT_MASK =
    32'(((64'd1 << NUM_COUNTERS) - 64'd1) << HPM_FIRST_COUNTER);

  logic [31:0]             inhibit_q, inhibit_d;
  logic                    inh_we;
  logic [31:0]             wval;
  logic [NUM_COUNTERS-1:0] evt_we, lo_we, hi_we, irq_src;
  logic [31:0]             evt_rdata [NUM_COUNTERS];
  logic [31:0]             lo_rdata  [NUM_COUNTERS];
  logic [31:0]             hi_rdata  [NUM_COUNTERS];
  logic                    irq_q, irq_d;

  always_comb begin
    csrHit     = 1'b0;
    csrReadOut = '0;
    inh_we     = 1'b0;
    evt_we     = '0;
    lo_we      = '0;
    hi_we      = '0;
    if (csrNumber == CSR_MCOUNTINHIBIT) begin
      csrHit     = 1'b1;
      csrReadOut = inhibit_q;
      inh_we     = csrWE;
    end
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      if (csrNumber == CSR_MHPMEVENT_BASE + 12'(i)) begin
        csrHit     = 1'b1;
        csrReadOut = evt_rdata[i];
        evt_we[i]  = csrWE;
      end
      if (csrNumber == CSR_MHPMCOUNTER_BASE + 12'(i)) begin
        csrHit     = 1'b1;
        csrReadOut = lo_rdata[i];
        lo_we[i]   = csrWE;
      end
      if (csrNumber == CSR_MHPMCOUNTERH_BASE + 12'(i)) begin
        csrHit     = 1'b1;
        csrReadOut = hi_rdata[i];
        hi_we[i]   = csrWE;
      end
    end
  end

  // Read-modify-write value shared by every owned register
  assign wval = csr_apply_op(csrCode, csrReadOut, csrWriteIn);

  always_comb begin
    inhibit_d = inhibit_q;
    if (inh_we) inhibit_d = wval & INHIBIT_MASK;
    irq_d = |irq_src;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inhibit_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      inhibit_q <= inhibit_d;
      irq_q     <= irq_d;
    end
  end

  assign overflowIrq = irq_q;

  for (genvar i = 0; i < NUM_COUNTERS; i++) begin : g_slice
    hpm_counter_slice #(
      .COUNTER_WIDTH  (COUNTER_WIDTH),
      .NUM_EVENTS     (NUM_EVENTS),
      .EVENT_INC_WIDTH(EVENT_INC_WIDTH)
    ) u_slice (
      .clk         (clk),
      .rst         (rst),
      .evt_we      (evt_we[i]),
      .cnt_lo_we   (lo_we[i]),
      .cnt_hi_we   (hi_we[i]),
      .wdata       (wval),
      .inhibit     (inhibit_q[HPM_FIRST_COUNTER+i]),
      .event_inc   (eventInc),
      .evt_rdata   (evt_rdata[i]),
      .cnt_lo_rdata(lo_rdata[i]),
      .cnt_hi_rdata(hi_rdata[i]),
      .irq_src     (irq_src[i])
    );
  end

endmodule

// File: doc/hpm_counter_bank.md
# hpm_counter_bank

- Parametrised bank of RISC-V machine hardware performance counters (`mhpmcounter3..`, matching `h` halves, `mhpmevent3..`, `mcountinhibit`).
- Each counter has a software-selectable event source, an inhibit bit, and a sticky overflow flag that raises a local interrupt request.
- Sits beside the CSR unit on the CSR access path: the CSR unit forwards CSR numbers, write requests and read-data selection; pipeline stages drive the event increment vector.
- Replaces the fixed four hardwired performance counters.

## Interface
Parameters:
- `NUM_COUNTERS`, 4: counters 3..3+NUM_COUNTERS-1; legal range 1..29.
- `COUNTER_WIDTH`, 64: counter width; legal range 1..64.
- `NUM_EVENTS`, 8: number of event input lanes; event select codes 1..NUM_EVENTS.
- `EVENT_INC_WIDTH`, 3: width of each lane's per-cycle increment (commit-width events).

Ports:
- Clock and reset: clk (input), rst (input), one clock, synchronous active-high reset.
- `csrNumber`  in  12  CSR address being read or written.
- `csrWE`  in  1  write request, qualified by a hit on `csrNumber`.
- `csrCode`  in  2  CSR write op: WRITE / SET / CLEAR, same encoding as the CSR unit.
- `csrWriteIn`  in  32  write operand.
- `csrHit`  out  1  `csrNumber` decodes to a register owned by this block.
- `csrReadOut`  out  32  combinational read data; 0 when `csrHit`=0.
- `eventInc`  in  NUM_EVENTS*EVENT_INC_WIDTH  per-lane increment for this cycle; lane k occupies bits [k*W +: W].
- `overflowIrq`  out  1  registered OR of all enabled overflow flags.

## Operation
- Owned CSRs:
  - `mcountinhibit` 0x320: bits 3..3+N-1 are writable; all other bits read 0.
  - `mhpmevent`i 0x323+j: bits[7:0] select the event; bit 31 OF is sticky; bit 30 OFIE enables the interrupt; other bits read 0.
  - `mhpmcounter`i 0xB03+j: low 32 bits of the counter.
  - `mhpmcounterh`i 0xB83+j: upper bits of the counter; reads 0 and ignores writes when COUNTER_WIDTH≤32.
  - Counter bits at or above COUNTER_WIDTH read 0 and are not stored.
- Write value: WRITE → operand; SET → read|operand; CLEAR → read&~operand.
- Event select:
  - Code 0 means no counting.
  - Codes 1..NUM_EVENTS select lane code-1.
  - Codes above NUM_EVENTS are stored but count nothing.
- Increment path, stage 1: each slice registers the selected lane's value (zero-extended) into `incStage`, using the selector value current in that cycle.
- Increment path, stage 2:
  - The counter adds `incStage` unless its inhibit bit is set at this stage.
  - A carry out of bit COUNTER_WIDTH-1 sets OF and wraps the counter modulo 2^COUNTER_WIDTH.
- Write precedence:
  - A write to a counter's low or high half at edge t replaces that half and preserves the other half.
  - The stage-2 increment for that counter at the same edge is discarded and no OF is set.
  - A software write to `mhpmevent` OF wins over a hardware OF set at the same edge.
- `overflowIrq` = registered OR over i of (OF_i & OFIE_i).

## Timing
- Reset values: all counters, selectors, OF, OFIE, `mcountinhibit`, `incStage` and `overflowIrq` are 0.
- After reset every owned CSR reads 0.
- Read latency: 0 cycles. `csrReadOut` reflects register state before the current edge.
- Event latency: an event presented in cycle t is visible in `csrReadOut` from cycle t+2.
- Overflow latency:
  - OF is visible at t+2.
  - `overflowIrq` rises at t+3.
  - `overflowIrq` falls one cycle after OF or OFIE is cleared.
- A selector write at edge t affects events sampled from cycle t+1 onward.
- An inhibit write at edge t blocks increments applied from edge t+1 onward, including a stage-1 value already in flight.
- Reset asserted mid-operation clears all state at that edge. Events in flight are lost.

## Structure
- Shared package `HPM_CounterTypes`, contents:
  - CSR number constants and base offsets.
  - `HPM_EventSelPath` (8 bits).
  - `HPM_EventCode` enum: none, load miss, store miss, IC miss, branch mispredict, committed ops, and later codes.
  - Field positions of OF and OFIE.
  - The CSR operation code is taken from the existing CSR unit types package.
- Sub-module `hpm_counter_slice`, one per counter:
  - Holds the selector register, `incStage`, the counter, OF and OFIE.
  - Takes a decoded write strobe, the write value and the lane vector.
- The top level contains:
  - Address decode.
  - Read multiplexer.
  - `mcountinhibit`.
  - `overflowIrq` OR-reduction.

## Test plan
- Reset check: after reset, read 0x320, 0x323, 0xB03 and 0xB83 → all 0; `overflowIrq`=0; `csrHit`=1 for each address and 0 for 0x300.
- Event counting: write `mhpmevent3`=1, drive lane 0 = 3 for 10 cycles → `mhpmcounter3` reads 30 two cycles after the last event; `mhpmcounter4` reads 0.
- Inhibit and selector changes:
  - SET bit 3 of `mcountinhibit` mid-stream → the count freezes from the next edge.
  - CLEAR it → counting resumes.
  - Selector 200 → no counting.
- Overflow interrupt: write `mhpmcounterh3`=0xFFFFFFFF and `mhpmcounter3`=0xFFFFFFFE with OFIE=1, drive inc 3 for one cycle → counter reads 1; OF=1 at t+2; `overflowIrq`=1 at t+3; CLEAR OF → IRQ drops one cycle later.
- Write collision: write 0x100 to `mhpmcounter3` in the same cycle a stage-2 increment of 5 is pending → reads 0x100; the upper half is unchanged.
- Narrow counter (COUNTER_WIDTH=40):
  - Write 0xFFFFFFFF to `mhpmcounterh3` → reads back 0xFF.
  - Wrap from 2^40-1 +1 → 0 with OF set.
